// File: rtl/tabla_barrido_pkg.sv
// Shared types and helpers for the truth-table sweeper.
// Used by the RTL and by benches that drive it.
package tabla_barrido_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of vectors visited by one sweep of an n-bit input.
    function automatic int sweep_len(input int n);
        return 32'd1 << n;
    endfunction

endpackage

// File: rtl/tabla_barrido_bin2gray.sv
// N-bit binary to reflected Gray encoder.
// Purely combinational.
module tabla_barrido_bin2gray #(
    parameter int N = 5
) (
    input  logic [N-1:0] bin,
    output logic [N-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/tabla_barrido.sv
// Exhaustive truth-table sweeper comparing two single-bit implementations.
// Steps vec through every value, dwells, counts mismatches and the first one.
module tabla_barrido
    import tabla_barrido_pkg::*;
#(
    parameter int N_IN  = 5,
    parameter int DWELL = 1,
    parameter bit GRAY  = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            f_a,
    input  logic            f_b,
    output logic [N_IN-1:0] vec,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            err_valid,
    output logic [N_IN-1:0] first_err
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]   DC_LAST  = DW'(DWELL - 1);
    localparam logic [N_IN-1:0] IDX_LAST = N_IN'(sweep_len(N_IN) - 1);

    state_t          state;
    logic [N_IN-1:0] idx;
    logic [DW-1:0]   dc;
    logic [N_IN-1:0] idx_next;
    logic [N_IN-1:0] enc_next;
    logic            mism;

    assign idx_next = idx + 1'b1;
    assign mism     = f_a ^ f_b;

    // Encode the next index as it is loaded into the vec register.
    generate
        if (GRAY) begin : g_gray
            tabla_barrido_bin2gray #(
                .N(N_IN)
            ) u_bin2gray (
                .bin  (idx_next),
                .gray (enc_next)
            );
        end else begin : g_bin
            assign enc_next = idx_next;
        end
    endgenerate

    // Sweep FSM with dwell counter and error capture; all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            dc        <= '0;
            vec       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            err_valid <= 1'b0;
            first_err <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        idx       <= '0;
                        dc        <= '0;
                        vec       <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        err_valid <= 1'b0;
                        first_err <= '0;
                    end
                end
                RUN: begin
                    if (dc == DC_LAST) begin
                        dc <= '0;
                        if (mism) begin
                            err_count <= err_count + 1'b1;
                            if (!err_valid) begin
                                err_valid <= 1'b1;
                                first_err <= vec;
                            end
                        end
                        if (idx == IDX_LAST) begin
                            // Last compare: vec keeps the final vector.
                            state <= DONE;
                            idx   <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_count == '0) && !mism;
                        end else begin
                            idx <= idx_next;
                            vec <= enc_next;
                        end
                    end else begin
                        dc <= dc + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tabla_barrido.sv
// Randomized self-checking bench for tabla_barrido.
// Two instances: binary/DWELL=1 and Gray/DWELL=3.
module tb_tabla_barrido;
    import tabla_barrido_pkg::*;

    localparam int N   = 5;
    localparam int LEN = sweep_len(N);

    logic         clk = 1'b0;
    logic         rst;
    logic         start_a, start_b;
    logic         fa_a, fb_a, fa_b, fb_b;
    logic [N-1:0] vec_a, vec_b, fe_a, fe_b;
    logic         busy_a, busy_b, done_a, done_b;
    logic         pass_a, pass_b, ev_a, ev_b;
    logic [N:0]   ec_a, ec_b;

    bit           use_sop;
    logic [31:0]  tt;
    logic [31:0]  mask;
    bit           sel;

    logic [N-1:0] vec_o, fe_o;
    logic         busy_o, done_o, pass_o, ev_o;
    logic [N:0]   ec_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tabla_barrido #(.N_IN(N), .DWELL(1), .GRAY(1'b0)) u_bin (
        .clk(clk), .rst(rst), .start(start_a),
        .f_a(fa_a), .f_b(fb_a),
        .vec(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(ec_a), .err_valid(ev_a), .first_err(fe_a)
    );

    tabla_barrido #(.N_IN(N), .DWELL(3), .GRAY(1'b1)) u_gray (
        .clk(clk), .rst(rst), .start(start_b),
        .f_a(fa_b), .f_b(fb_b),
        .vec(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(ec_b), .err_valid(ev_b), .first_err(fe_b)
    );

    // Implementation A: SOP form or a random truth table.
    function automatic logic ref_fa(input logic [N-1:0] v);
        if (use_sop) return (v[0] & v[1]) | v[2];
        return tt[v];
    endfunction

    // Implementation B: equivalent POS form, with planted faults from mask.
    function automatic logic ref_fb(input logic [N-1:0] v);
        logic r;
        if (use_sop) r = (v[0] | v[2]) & (v[1] | v[2]);
        else         r = tt[v];
        return r ^ mask[v];
    endfunction

    function automatic int enc(input int i, input bit g);
        return g ? (i ^ (i >> 1)) : i;
    endfunction

    always_comb begin
        fa_a = ref_fa(vec_a);
        fb_a = ref_fb(vec_a);
        fa_b = ref_fa(vec_b);
        fb_b = ref_fb(vec_b);
    end

    always_comb begin
        vec_o  = sel ? vec_b  : vec_a;
        fe_o   = sel ? fe_b   : fe_a;
        busy_o = sel ? busy_b : busy_a;
        done_o = sel ? done_b : done_a;
        pass_o = sel ? pass_b : pass_a;
        ev_o   = sel ? ev_b   : ev_a;
        ec_o   = sel ? ec_b   : ec_a;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_start(input bit s, input logic val);
        if (s) start_b = val;
        else   start_a = val;
    endtask

    // One full sweep, checked against a model built from the sweep order.
    task automatic sweep(input bit s, input int dwell, input bit g,
                         input int poke);
        int  e_cnt = 0;
        int  e_first = 0;
        bit  e_valid = 1'b0;
        int  v;
        for (int i = 0; i < LEN; i++) begin
            v = enc(i, g);
            if (ref_fa(N'(v)) != ref_fb(N'(v))) begin
                if (!e_valid) e_first = v;
                e_valid = 1'b1;
                e_cnt++;
            end
        end
        sel = s;
        @(negedge clk);
        set_start(s, 1'b1);
        @(posedge clk);
        #1;
        set_start(s, 1'b0);
        check("start_busy", 32'(busy_o), 1);
        check("start_done", 32'(done_o), 0);
        check("start_pass", 32'(pass_o), 0);
        check("start_errcnt", 32'(ec_o), 0);
        check("start_errvalid", 32'(ev_o), 0);
        check("start_firsterr", 32'(fe_o), 0);
        for (int k = 0; k < LEN * dwell; k++) begin
            if (k % dwell == 0) begin
                check("run_vec", 32'(vec_o), 32'(enc(k / dwell, g)));
                check("run_busy", 32'(busy_o), 1);
            end
            if (k == poke) set_start(s, 1'b1);
            @(posedge clk);
            #1;
            set_start(s, 1'b0);
        end
        check("end_busy", 32'(busy_o), 0);
        check("end_done", 32'(done_o), 1);
        check("end_pass", 32'(pass_o), 32'(e_cnt == 0));
        check("end_errcnt", 32'(ec_o), 32'(e_cnt));
        check("end_errvalid", 32'(ev_o), 32'(e_valid));
        check("end_firsterr", 32'(fe_o), 32'(e_first));
        check("end_vec", 32'(vec_o), 32'(enc(LEN - 1, g)));
        @(posedge clk);
        #1;
        check("hold_done", 32'(done_o), 1);
        check("hold_errcnt", 32'(ec_o), 32'(e_cnt));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_vec"}, 32'(vec_o), 0);
        check({tag, "_busy"}, 32'(busy_o), 0);
        check({tag, "_done"}, 32'(done_o), 0);
        check({tag, "_pass"}, 32'(pass_o), 0);
        check({tag, "_errcnt"}, 32'(ec_o), 0);
        check({tag, "_errvalid"}, 32'(ev_o), 0);
        check({tag, "_firsterr"}, 32'(fe_o), 0);
    endtask

    initial begin
        int  waited;
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        use_sop = 1'b1;
        tt      = '0;
        mask    = '0;
        sel     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst_a");
        sel = 1'b1;
        #1;
        check_reset_state("rst_b");
        @(negedge clk);
        rst = 1'b0;

        // Equivalent SOP/POS forms.
        sweep(1'b0, 1, 1'b0, -1);
        // Single fault at vec=7, started back-to-back from DONE.
        mask = 32'h0000_0080;
        sweep(1'b0, 1, 1'b0, -1);
        // Complementary implementation.
        use_sop = 1'b0;
        tt      = $urandom;
        mask    = 32'hFFFF_FFFF;
        sweep(1'b0, 1, 1'b0, -1);
        // Gray order with dwell 3, SOP/POS equal.
        use_sop = 1'b1;
        mask    = '0;
        sweep(1'b1, 3, 1'b1, -1);
        // Gray order with random faults.
        use_sop = 1'b0;
        tt      = $urandom;
        mask    = $urandom & $urandom;
        sweep(1'b1, 3, 1'b1, -1);
        // start during RUN is ignored.
        mask = $urandom & $urandom & $urandom;
        sweep(1'b0, 1, 1'b0, 5);
        sweep(1'b1, 3, 1'b1, 5);

        // Reset mid-sweep when vec reaches 10.
        sel = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        waited = 0;
        while (vec_o != N'(10) && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("reach_vec10", 32'(vec_o), 10);
        rst = 1'b1;
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_rst", 32'(busy_o), 0);
        sweep(1'b0, 1, 1'b0, -1);

        // A few more random sweeps on both instances.
        for (int r = 0; r < 4; r++) begin
            use_sop = 1'($urandom_range(0, 1));
            tt      = $urandom;
            mask    = (r == 0) ? 32'h0 : ($urandom & $urandom);
            sweep(1'(r % 2), (r % 2 == 1) ? 3 : 1, 1'(r % 2), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
